// File: rtl/uart_tx_module.sv
// uart_tx_module: 8N1 UART transmitter, one byte per request, LSB first.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   tx_en_sig  request level, held by the requester until tx_done
//   tx_data    byte to send, latched when a frame starts
//   tx_done    one-cycle pulse after the stop bit completes
//   tx_pin     registered serial line, idle high
//
// Parameter BPS is the number of clk cycles per bit (434 = 50 MHz / 115200).
module uart_tx_module #(
   parameter int unsigned BPS = 434
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       tx_en_sig,
   input  logic [7:0] tx_data,
   output logic       tx_done,
   output logic       tx_pin
);

   typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

   localparam logic [12:0] BAUD_LAST = 13'(BPS - 1);

   state_t      state, state_n;
   logic [3:0]  bit_idx, bit_idx_n;
   logic [12:0] baud_cnt, baud_cnt_n;
   logic [7:0]  shreg, shreg_n;
   logic        pin_n, done_n;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         bit_idx  <= 4'd0;
         baud_cnt <= 13'd0;
         shreg    <= 8'd0;
         tx_pin   <= 1'b1;
         tx_done  <= 1'b0;
      end else begin
         state    <= state_n;
         bit_idx  <= bit_idx_n;
         baud_cnt <= baud_cnt_n;
         shreg    <= shreg_n;
         tx_pin   <= pin_n;
         tx_done  <= done_n;
      end
   end

   // tx_pin is registered, so the line value is computed for the bit that
   // becomes current on the next edge. The shift register holds the data bits
   // not yet put on the line; its LSB is the next data bit.
   always_comb begin
      state_n    = state;
      bit_idx_n  = bit_idx;
      baud_cnt_n = baud_cnt;
      shreg_n    = shreg;
      pin_n      = tx_pin;
      done_n     = 1'b0;
      case (state)
         IDLE: begin
            pin_n = 1'b1;
            if (tx_en_sig) begin
               state_n    = SEND;
               bit_idx_n  = 4'd0;
               baud_cnt_n = 13'd0;
               shreg_n    = tx_data;
               pin_n      = 1'b0;              // start bit
            end
         end
         SEND: begin
            if (baud_cnt == BAUD_LAST) begin
               baud_cnt_n = 13'd0;
               if (bit_idx == 4'd9) begin
                  // end of stop bit: pulse done, line stays high
                  state_n   = DONE;
                  bit_idx_n = 4'd0;
                  pin_n     = 1'b1;
                  done_n    = 1'b1;
               end else begin
                  bit_idx_n = bit_idx + 4'd1;
                  if (bit_idx < 4'd8) begin
                     pin_n   = shreg[0];
                     shreg_n = {1'b0, shreg[7:1]};
                  end else begin
                     pin_n   = 1'b1;           // stop bit
                  end
               end
            end else begin
               baud_cnt_n = baud_cnt + 13'd1;
            end
         end
         DONE: begin
            // request level is ignored here; always one idle pass first
            state_n = IDLE;
            pin_n   = 1'b1;
         end
         default: begin
            state_n = IDLE;
            pin_n   = 1'b1;
         end
      endcase
   end

endmodule

// File: tb/tb_uart_tx_module.sv
module tb_uart_tx_module;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       en0 = 1'b0, en1 = 1'b0;
   logic [7:0] d0 = 8'h00, d1 = 8'h00;
   logic       done0, done1, pin0, pin1;

   int n_chk = 0;
   int n_err = 0;

   always #10 clk = ~clk;   // 50 MHz

   uart_tx_module #(.BPS(434)) u_434 (
      .clk(clk), .rst_n(rst_n), .tx_en_sig(en0), .tx_data(d0),
      .tx_done(done0), .tx_pin(pin0));

   uart_tx_module #(.BPS(104)) u_104 (
      .clk(clk), .rst_n(rst_n), .tx_en_sig(en1), .tx_data(d1),
      .tx_done(done1), .tx_pin(pin1));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic pin_of(input int u);
      return (u != 0) ? pin1 : pin0;
   endfunction

   function automatic logic done_of(input int u);
      return (u != 0) ? done1 : done0;
   endfunction

   task automatic set_req(input int u, input logic en, input logic [7:0] d);
      if (u != 0) begin en1 = en; d1 = d; end
      else        begin en0 = en; d0 = d; end
   endtask

   task automatic set_en(input int u, input logic en);
      if (u != 0) en1 = en; else en0 = en;
   endtask

   task automatic set_data(input int u, input logic [7:0] d);
      if (u != 0) d1 = d; else d0 = d;
   endtask

   // Reference: frame bit k of byte d, 8N1 LSB first.
   function automatic logic frame_bit(input logic [7:0] d, input int k);
      if (k == 0) return 1'b0;
      if (k == 9) return 1'b1;
      return d[k-1];
   endfunction

   // Send one byte with the enable/done handshake and check the whole frame.
   // Sample index t counts negedges after the request edge (t=0 is the first
   // cycle of the start bit).
   task automatic send(input int u, input logic [7:0] d, input bit mid_change);
      int bps;
      int bad_cycles;
      int n_done;
      int done_at;
      int gap_bad;
      bps = (u != 0) ? 104 : 434;
      bad_cycles = 0; n_done = 0; done_at = -1; gap_bad = 0;
      @(negedge clk);
      set_req(u, 1'b1, d);
      @(posedge clk);
      for (int t = 0; t <= 10 * bps; t++) begin
         @(negedge clk);
         if (t == 0) chk("start_low", {31'd0, pin_of(u)}, 32'd0);
         if (t < 10 * bps) begin
            if (pin_of(u) !== frame_bit(d, t / bps)) bad_cycles++;
            if (t % bps == bps / 2)
               chk($sformatf("bit%0d_%02h", t / bps, d), {31'd0, pin_of(u)},
                   {31'd0, frame_bit(d, t / bps)});
         end else if (pin_of(u) !== 1'b1) begin
            bad_cycles++;
         end
         if (done_of(u) === 1'b1) begin
            n_done++;
            done_at = t;
            set_en(u, 1'b0);
         end
         if (mid_change && t == bps) set_data(u, 8'h00);
      end
      chk("line_cycles", bad_cycles, 0);
      chk("done_count", n_done, 1);
      chk("done_time", done_at, 10 * bps);
      for (int t = 0; t < 20; t++) begin
         @(negedge clk);
         if (pin_of(u) !== 1'b1 || done_of(u) !== 1'b0) gap_bad++;
      end
      chk("idle_gap", gap_bad, 0);
   endtask

   // Start a frame on the BPS=434 instance and reset in the middle of data bit 4.
   task automatic abort_frame(input logic [7:0] d);
      int stray;
      stray = 0;
      @(negedge clk);
      set_req(0, 1'b1, d);
      @(posedge clk);
      for (int t = 0; t < 5 * 434 + 217; t++) @(negedge clk);
      chk("pre_abort_bit4", {31'd0, pin0}, {31'd0, d[4]});
      rst_n = 1'b0;
      #1;
      chk("abort_pin", {31'd0, pin0}, 32'd1);
      chk("abort_done", {31'd0, done0}, 32'd0);
      en0 = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      for (int t = 0; t < 100; t++) begin
         @(negedge clk);
         if (done0 !== 1'b0 || pin0 !== 1'b1) stray++;
      end
      chk("abort_quiet", stray, 0);
   endtask

   initial begin
      int bad;
      logic [7:0] rb;
      bad = 0;
      // reset held for 1 us
      for (int t = 0; t < 50; t++) begin
         @(negedge clk);
         if (pin0 !== 1'b1 || done0 !== 1'b0 || pin1 !== 1'b1 || done1 !== 1'b0) bad++;
      end
      chk("reset_hold", bad, 0);
      rst_n = 1'b1;
      bad = 0;
      for (int t = 0; t < 100; t++) begin
         @(negedge clk);
         if (pin0 !== 1'b1 || done0 !== 1'b0 || pin1 !== 1'b1 || done1 !== 1'b0) bad++;
      end
      chk("post_reset_idle", bad, 0);

      send(0, 8'h2E, 1'b0);                 // single byte
      send(0, 8'h2E, 1'b0);                 // three-byte sequence
      send(0, 8'h3F, 1'b0);
      send(0, 8'hDD, 1'b0);
      send(0, 8'h3F, 1'b1);                 // tx_data cleared mid-frame
      abort_frame(8'h5A);                   // bit 4 of 0x5A is 1
      send(0, 8'hA7, 1'b0);                 // complete frame after abort
      send(1, 8'hDD, 1'b0);                 // BPS=104
      for (int i = 0; i < 8; i++) begin
         rb = 8'($urandom_range(0, 255));
         repeat ($urandom_range(0, 5)) @(negedge clk);
         send(1, rb, ($urandom_range(0, 1) == 1));
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/uart_tx_module.md
Name:
uart_tx_module

Overview:
- UART transmit serializer for one byte per request: 8N1 framing, LSB first, idle-high line.
- Enable-level handshake: the requester holds tx_en_sig high until a one-cycle tx_done pulse.
- Sits between a byte-producing controller and the board TX pin. Default timing is 50 MHz clk, 115200 baud.

Parameters:
- BPS, default 434 (13 bits): clk cycles per bit. 5208 = 50 MHz/9600; 1250 = 12 MHz/9600; 104 = 12 MHz/115200.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- tx_en_sig  input  1  transmit request level; held high by requester until tx_done.
- tx_data  input  8  byte to send; sampled when a frame starts.
- tx_done  output  1  one-cycle pulse, frame (incl. stop bit) complete.
- tx_pin  output  1  serial line; idle 1.

Behaviour:
- Reset (rst_n low, asynchronous):
  - tx_pin=1, tx_done=0.
  - Bit counter, baud counter and state cleared to IDLE; shift register=0.
- States:
  - IDLE -> SEND (bits 0..9) -> DONE -> IDLE.
- IDLE:
  - tx_pin=1, tx_done=0.
  - On a rising edge with tx_en_sig=1: latch tx_data, enter SEND at bit 0, clear baud counter.
- SEND:
  - Frame: bit 0 = start (0), bits 1..8 = data[0]..data[7] (LSB first), bit 9 = stop (1).
  - tx_pin is registered. It shows the start bit from the first cycle after the request edge.
  - Each bit lasts exactly BPS clk cycles; baud counter runs 0..BPS-1, then wraps to 0 and advances the bit index.
  - Frame length is exactly 10*BPS cycles.
- DONE:
  - Entered after the last stop-bit cycle.
  - tx_done=1 for exactly one cycle; tx_pin stays 1.
  - tx_en_sig is ignored in this cycle.
  - Next state is IDLE unconditionally.
- Back-to-back frames:
  - The requester drops tx_en_sig on the edge it sees tx_done; IDLE then sees low.
  - A new request with new data may come the next cycle; it is accepted normally.
  - If tx_en_sig is still high on the first IDLE cycle after DONE, a new frame starts (level-triggered). This is legal.
- Mid-frame input changes:
  - tx_en_sig dropping mid-frame does not abort the frame.
  - tx_data changes mid-frame do not affect the frame; the latched copy is used.
- Reset mid-frame: immediate abort, tx_pin=1, no tx_done pulse.
- Widths: baud counter 13 bits; bit index 4 bits.

Test Plan:
- Reset:
  - Stimulus: hold rst_n=0 for 1 us, tx_en_sig=0.
  - Required: tx_pin=1, tx_done=0 throughout, and for 100 cycles after release.
- Single byte 0x2E, BPS=434:
  - Stimulus: assert tx_en_sig with data 0x2E.
  - Required: tx_pin low one cycle after the request edge.
  - Required: sampled at each bit centre (217+434k cycles), the line reads 0,0,1,1,1,0,1,0,0,1.
  - Required: tx_done high exactly 1 cycle, 4340 cycles after the start bit begins.
- Three-byte sequence 0x2E, 0x3F, 0xDD with the enable/done handshake:
  - Required: three correct frames, three single-cycle tx_done pulses.
  - Required: line idle high between frames; no extra or duplicated frame.
- Data change mid-frame:
  - Stimulus: send 0x3F, drive tx_data=0x00 after the start bit.
  - Required: transmitted data bits still 1,1,1,1,1,1,0,0.
- Reset during data bit 4:
  - Required: tx_pin returns to 1 immediately, no tx_done.
  - Required: the next request transmits a complete, correct frame.
- Parameter BPS=104:
  - Stimulus: send 0xDD.
  - Required: frame lasts 1040 cycles.
  - Required: bits read 0,1,0,1,1,1,0,1,1,1.
